// File: rtl/seg_scan_pkg.sv
// Shared types and constants for the multiplexed 7-segment scanner.
package seg_scan_pkg;

    localparam int NUM_DIGITS = 8;
    localparam int IDX_W      = 3;

    // Two-state scan FSM: dark blanking interval, then the lit digit.
    typedef logic [0:0] scan_state_t;
    localparam scan_state_t BLANK = 1'b0;
    localparam scan_state_t SHOW  = 1'b1;

    localparam logic [6:0] SEG_OFF = 7'h7F;
    localparam logic [7:0] AN_OFF  = 8'hFF;

    // Counter width able to hold (max(a,b) - 1); never narrower than one bit.
    function automatic int cnt_width(input int a, input int b);
        int m;
        m = (a > b) ? a : b;
        return (m > 1) ? $clog2(m) : 1;
    endfunction

endpackage

// File: rtl/seg_scan_driver_slot_timer.sv
// Per-phase cycle counter: counts 0..limit, pulses done on the last cycle
// of the phase and wraps to zero on its own.
module slot_timer
    import seg_scan_pkg::*;
#(
    parameter int WIDTH = 1
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             clr,
    input  logic [WIDTH-1:0] limit,
    output logic [WIDTH-1:0] cnt,
    output logic             done
);

    // done is high exactly while the counter sits on the active limit.
    assign done = (cnt == limit);

    // Count up, restarting at zero after the last cycle or on clear.
    // NOTE: sequential state uses non-blocking (<=) so every register samples
    // pre-edge values; blocking (=) here would create order-dependent races.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            cnt <= '0;
        end else if (clr || done) begin
            cnt <= '0;
        end else begin
            cnt <= cnt + 1'b1;
        end
    end

endmodule

// File: rtl/seg_scan_driver.sv
// Time-multiplexed 8-digit 7-segment scanner with per-slot blanking and
// per-frame snapshot of the digit patterns to avoid tearing.
module seg_scan_driver
    import seg_scan_pkg::*;
#(
    parameter int DIGIT_CYCLES = 50000,
    parameter int BLANK_CYCLES = 500
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       enable,
    input  logic [7:0] digit_en,
    input  logic [6:0] hex0,
    input  logic [6:0] hex1,
    input  logic [6:0] hex2,
    input  logic [6:0] hex3,
    input  logic [6:0] hex4,
    input  logic [6:0] hex5,
    input  logic [6:0] hex6,
    input  logic [6:0] hex7,
    output logic [6:0] seg_n,
    output logic [7:0] an_n,
    output logic [2:0] digit_idx,
    output logic       frame_tick
);

    localparam int CNT_W = cnt_width(DIGIT_CYCLES, BLANK_CYCLES);
    localparam logic [CNT_W-1:0] BLANK_LIM = CNT_W'(BLANK_CYCLES - 1);
    localparam logic [CNT_W-1:0] SHOW_LIM  = CNT_W'(DIGIT_CYCLES - 1);

    scan_state_t      state, state_d;
    logic [IDX_W-1:0] idx, idx_d;
    logic [CNT_W-1:0] cnt, limit;
    logic             done, load;
    logic [6:0]       hex    [NUM_DIGITS];
    logic [6:0]       snap   [NUM_DIGITS];
    logic [6:0]       snap_d [NUM_DIGITS];
    logic [6:0]       seg_d;
    logic [7:0]       an_d;

    assign hex[0] = hex0;
    assign hex[1] = hex1;
    assign hex[2] = hex2;
    assign hex[3] = hex3;
    assign hex[4] = hex4;
    assign hex[5] = hex5;
    assign hex[6] = hex6;
    assign hex[7] = hex7;

    assign limit     = (state == BLANK) ? BLANK_LIM : SHOW_LIM;
    assign digit_idx = idx;

    slot_timer #(
        .WIDTH(CNT_W)
    ) u_timer (
        .clk  (clk),
        .rst  (rst),
        .clr  (!enable),
        .limit(limit),
        .cnt  (cnt),
        .done (done)
    );

    // Next state, next snapshot and next outputs, all derived from the same
    // post-edge view so the registered outputs always match the state.
    always_comb begin
        // NOTE: every signal gets a default before any branch so no path
        // leaves it unassigned; a missing default would infer a latch.
        load = enable && (state == BLANK) && (idx == '0) && (cnt == '0);
        for (int i = 0; i < NUM_DIGITS; i++) begin
            snap_d[i] = load ? hex[i] : snap[i];
        end

        state_d = state;
        idx_d   = idx;
        if (!enable) begin
            state_d = BLANK;
            idx_d   = '0;
        end else if (done) begin
            if (state == BLANK) begin
                state_d = SHOW;
            end else begin
                state_d = BLANK;
                idx_d   = idx + 1'b1;
            end
        end

        // Snapshot value (not the live register) feeds the segments so a
        // one-cycle blanking interval still shows the freshly loaded frame.
        seg_d = SEG_OFF;
        an_d  = AN_OFF;
        if (state_d == SHOW) begin
            seg_d = snap_d[idx_d];
            if (digit_en[idx_d]) begin
                an_d = ~(8'b1 << idx_d);
            end
        end
    end

    // FSM, slot index and registered display outputs.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state      <= BLANK;
            idx        <= '0;
            seg_n      <= SEG_OFF;
            an_n       <= AN_OFF;
            frame_tick <= 1'b0;
        end else begin
            state      <= state_d;
            idx        <= idx_d;
            seg_n      <= seg_d;
            an_n       <= an_d;
            frame_tick <= load;
        end
    end

    // Frame snapshot of the eight digit patterns.
    // NOTE: this small register array is reset deliberately so the display is
    // dark, not random, if it is ever shown before the first load; large RAMs
    // would normally be left unreset.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            for (int i = 0; i < NUM_DIGITS; i++) begin
                snap[i] <= SEG_OFF;
            end
        end else begin
            for (int i = 0; i < NUM_DIGITS; i++) begin
                snap[i] <= snap_d[i];
            end
        end
    end

endmodule

// File: tb/tb_seg_scan_driver.sv
// Directed self-checking bench for seg_scan_driver (DIGIT=4, BLANK=2).
module tb_seg_scan_driver;

    localparam int D     = 4;
    localparam int B     = 2;
    localparam int SLOT  = D + B;
    localparam int FRAME = 8 * SLOT;

    logic       clk = 1'b0;
    logic       rst;
    logic       enable;
    logic [7:0] digit_en;
    logic [6:0] hex [8];
    logic [6:0] seg_n;
    logic [7:0] an_n;
    logic [2:0] digit_idx;
    logic       frame_tick;

    int n_cmp = 0;
    int n_bad = 0;

    logic [6:0] pat [8];

    always #5 clk = ~clk;

    seg_scan_driver #(
        .DIGIT_CYCLES(D),
        .BLANK_CYCLES(B)
    ) dut (
        .clk       (clk),
        .rst       (rst),
        .enable    (enable),
        .digit_en  (digit_en),
        .hex0      (hex[0]),
        .hex1      (hex[1]),
        .hex2      (hex[2]),
        .hex3      (hex[3]),
        .hex4      (hex[4]),
        .hex5      (hex[5]),
        .hex6      (hex[6]),
        .hex7      (hex[7]),
        .seg_n     (seg_n),
        .an_n      (an_n),
        .digit_idx (digit_idx),
        .frame_tick(frame_tick)
    );

    // At most one anode may ever be active.
    always @(negedge clk) begin
        n_cmp++;
        if (!$onehot0(~an_n)) begin
            n_bad++;
            $display("FAIL onehot an_n got %h want at most one low bit", an_n);
        end
    end

    // Check one full frame starting from the load cycle (frame position 0).
    // Optionally rewrites hex3 to chg_v right after position chg_f is checked.
    task automatic check_frame(input string name, input logic [6:0] exp_pat [8],
                               input logic [7:0] mask, input int chg_f,
                               input logic [6:0] chg_v);
        int ff, slot, pos;
        logic [6:0] e_seg;
        logic [7:0] e_an;
        logic       e_tick;
        for (int f = 1; f <= FRAME; f++) begin
            @(negedge clk);
            ff     = f % FRAME;
            slot   = ff / SLOT;
            pos    = ff % SLOT;
            e_tick = (ff == 1);
            if (pos < B) begin
                e_seg = 7'h7F;
                e_an  = 8'hFF;
            end else begin
                e_seg = exp_pat[slot];
                e_an  = mask[slot] ? ~(8'h01 << slot) : 8'hFF;
            end
            n_cmp++;
            if (seg_n !== e_seg) begin
                n_bad++;
                $display("FAIL %s f=%0d seg_n got %h want %h", name, f, seg_n, e_seg);
            end
            n_cmp++;
            if (an_n !== e_an) begin
                n_bad++;
                $display("FAIL %s f=%0d an_n got %h want %h", name, f, an_n, e_an);
            end
            n_cmp++;
            if (digit_idx !== 3'(slot)) begin
                n_bad++;
                $display("FAIL %s f=%0d digit_idx got %0d want %0d", name, f, digit_idx, slot);
            end
            n_cmp++;
            if (frame_tick !== e_tick) begin
                n_bad++;
                $display("FAIL %s f=%0d frame_tick got %b want %b", name, f, frame_tick, e_tick);
            end
            if (f == chg_f) hex[3] = chg_v;
        end
    endtask

    task automatic expect_dark(input string name, input logic [2:0] e_idx);
        n_cmp++;
        if (seg_n !== 7'h7F) begin
            n_bad++;
            $display("FAIL %s seg_n got %h want 7f", name, seg_n);
        end
        n_cmp++;
        if (an_n !== 8'hFF) begin
            n_bad++;
            $display("FAIL %s an_n got %h want ff", name, an_n);
        end
        n_cmp++;
        if (digit_idx !== e_idx) begin
            n_bad++;
            $display("FAIL %s digit_idx got %0d want %0d", name, digit_idx, e_idx);
        end
        n_cmp++;
        if (frame_tick !== 1'b0) begin
            n_bad++;
            $display("FAIL %s frame_tick got %b want 0", name, frame_tick);
        end
    endtask

    // Power-on reset, then an asynchronous reset in the middle of slot 1.
    task automatic test_reset();
        rst      = 1'b1;
        enable   = 1'b1;
        digit_en = 8'hFF;
        for (int i = 0; i < 8; i++) hex[i] = pat[i];
        repeat (3) @(negedge clk);
        expect_dark("por", 3'd0);
        rst = 1'b0;                      // now at frame position 0
        repeat (9) @(negedge clk);       // frame position 9: slot 1 lit
        n_cmp++;
        if (an_n !== 8'hFD) begin
            n_bad++;
            $display("FAIL pre_reset an_n got %h want fd", an_n);
        end
        #2 rst = 1'b1;
        #1 expect_dark("async_reset", 3'd0);
        @(negedge clk);
        expect_dark("held_reset", 3'd0);
        rst = 1'b0;                      // frame position 0 again
        check_frame("after_reset", pat, 8'hFF, -1, 7'h00);
    endtask

    // Second consecutive frame: period 48 and idx wrap 7->0.
    task automatic test_sweep();
        check_frame("sweep", pat, 8'hFF, -1, 7'h00);
    endtask

    // Change hex3 while slot 1 is lit: this frame keeps 30, the next shows 00.
    task automatic test_tearing();
        check_frame("tear_old", pat, 8'hFF, 9, 7'h00);
        pat[3] = 7'h00;
        check_frame("tear_new", pat, 8'hFF, -1, 7'h00);
    endtask

    // Even digits masked off; timing and frame period unchanged.
    task automatic test_mask();
        digit_en = 8'b1010_1010;
        check_frame("mask", pat, 8'b1010_1010, -1, 7'h00);
        digit_en = 8'hFF;
    endtask

    // Drop enable during slot 5, hold, then re-enable.
    task automatic test_enable_drop();
        repeat (33) @(negedge clk);      // frame position 33: slot 5 lit
        n_cmp++;
        if (an_n !== 8'hDF || digit_idx !== 3'd5) begin
            n_bad++;
            $display("FAIL pre_drop an_n/idx got %h/%0d want df/5", an_n, digit_idx);
        end
        enable = 1'b0;
        for (int k = 0; k < 8; k++) begin
            @(negedge clk);
            expect_dark("disabled", 3'd0);
        end
        enable = 1'b1;                   // this cycle is frame position 0
        check_frame("reenable", pat, 8'hFF, -1, 7'h00);
    endtask

    initial begin
        pat[0] = 7'h40; pat[1] = 7'h79; pat[2] = 7'h24; pat[3] = 7'h30;
        pat[4] = 7'h19; pat[5] = 7'h12; pat[6] = 7'h02; pat[7] = 7'h78;
        test_reset();
        test_sweep();
        test_tearing();
        test_mask();
        test_enable_drop();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
